wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter_pkg.sv | 42 ++++
 rtl/wb_arbiter_hold_slot.sv | 45 ++++
 rtl/wb_arbiter.sv | 137 +++++++++++++
 tb/tb_wb_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared types, widths and source encodings for the register-file writeback arbiter.
// Holds no state. Imported by wb_arbiter and wb_hold_slot.
// Defines the REG_BUS data-slice macro used on the external 64-bit data ports.
`ifndef WB_ARBITER_DEFINES
`define WB_ARBITER_DEFINES
`define REG_BUS 63:0
`endif

package wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_W      = 64;
  localparam int NUM_REGS   = 32;

  // The starvation counter saturates here, and pipe_stall is raised at this value.
  localparam logic [1:0] STARVE_MAX = 2'd3;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_W-1:0]      reg_data_t;

  // Origin of the write currently held in the registered regfile port.
  typedef enum logic [1:0] {
    SRC_PIPE = 2'd0,
    SRC_MD   = 2'd1,
    SRC_LS   = 2'd2
  } src_e;

  // Round-robin pointer value: the slow source that was granted most recently.
  typedef enum logic {
    RR_MD = 1'b0,
    RR_LS = 1'b1
  } rr_e;

  // One-hot register mask. Register 0 never produces a bit.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_addr_t addr);
    logic [NUM_REGS-1:0] mask;
    mask = '0;
    if (addr != '0) mask[addr] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/wb_arbiter_hold_slot.sv
// One-entry result buffer for a slow writeback source (addr + data, valid/ready in).
// Latency: a result accepted on an edge is offered for grant in the next cycle.
// Backpressure: ready = slot empty or being granted this cycle; ready is 0 during reset.
// Ports: clk/rst; valid/ready/waddr/wdata from the source; grant from the arbiter;
//        held/held_waddr/held_wdata toward the arbiter.
module wb_hold_slot
  import wb_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid,
  output logic                  ready,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [REG_W-1:0]      wdata,
  input  logic                  grant,
  output logic                  held,
  output logic [REG_ADDR_W-1:0] held_waddr,
  output logic [REG_W-1:0]      held_wdata
);

  logic accept;
  logic load;

  // Freeing on grant lets the slot refill in the same cycle, which sustains
  // one result per cycle when the port is uncontended.
  assign ready  = !rst && (!held || grant);
  assign accept = valid && ready;
  // A write to r0 completes the handshake but is dropped here.
  assign load   = accept && (waddr != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      held       <= 1'b0;
      held_waddr <= '0;
      held_wdata <= '0;
    end else if (load) begin
      held       <= 1'b1;
      held_waddr <= waddr;
      held_wdata <= wdata;
    end else if (grant) begin
      held <= 1'b0;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Arbitrates the single regfile write port between the in-order pipeline and the md/ls slow units.
// Latency: the granted write appears on rf_* one cycle after the grant; slow results are buffered one cycle first.
// Backpressure: slow sources see ready from their hold slots; the pipeline has none and is asked to pause via pipe_stall.
// Ports: pipe_* pipeline writeback; md_* / ls_* slow-result handshakes; iss_* slow-op issue marking;
//        rf_* registered regfile write; pend_mask pending-slow-write scoreboard; pipe_stall starvation relief.
module wb_arbiter
  import wb_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pipe_wen,
  input  logic [REG_ADDR_W-1:0] pipe_waddr,
  input  logic [`REG_BUS]       pipe_wdata,
  input  logic                  md_valid,
  output logic                  md_ready,
  input  logic [REG_ADDR_W-1:0] md_waddr,
  input  logic [`REG_BUS]       md_wdata,
  input  logic                  ls_valid,
  output logic                  ls_ready,
  input  logic [REG_ADDR_W-1:0] ls_waddr,
  input  logic [`REG_BUS]       ls_wdata,
  input  logic                  iss_valid,
  input  logic [REG_ADDR_W-1:0] iss_waddr,
  output logic                  rf_wen,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [`REG_BUS]       rf_wdata,
  output logic [NUM_REGS-1:0]   pend_mask,
  output logic                  pipe_stall
);

  logic                  md_held, ls_held;
  logic [REG_ADDR_W-1:0] md_held_waddr, ls_held_waddr;
  logic [REG_W-1:0]      md_held_wdata, ls_held_wdata;

  logic                  grant_pipe, grant_md, grant_ls;
  logic                  slow_grant, any_held;
  rr_e                   last_grant;
  logic [1:0]            starve_cnt;
  src_e                  rf_src;
  logic [NUM_REGS-1:0]   pend_next;

  wb_hold_slot u_md_slot (
    .clk        (clk),
    .rst        (rst),
    .valid      (md_valid),
    .ready      (md_ready),
    .waddr      (md_waddr),
    .wdata      (md_wdata),
    .grant      (grant_md),
    .held       (md_held),
    .held_waddr (md_held_waddr),
    .held_wdata (md_held_wdata)
  );

  wb_hold_slot u_ls_slot (
    .clk        (clk),
    .rst        (rst),
    .valid      (ls_valid),
    .ready      (ls_ready),
    .waddr      (ls_waddr),
    .wdata      (ls_wdata),
    .grant      (grant_ls),
    .held       (ls_held),
    .held_waddr (ls_held_waddr),
    .held_wdata (ls_held_wdata)
  );

  // Pipeline has absolute priority unless it targets r0, which never uses the port.
  // Grants do not depend on md_valid/ls_valid, so ready has no combinational loop.
  always_comb begin
    grant_pipe = pipe_wen && (pipe_waddr != '0);
    grant_md   = 1'b0;
    grant_ls   = 1'b0;
    if (!grant_pipe) begin
      if (md_held && ls_held) begin
        if (last_grant == RR_LS) grant_md = 1'b1;
        else                     grant_ls = 1'b1;
      end else if (md_held) begin
        grant_md = 1'b1;
      end else if (ls_held) begin
        grant_ls = 1'b1;
      end
    end
  end

  assign slow_grant = grant_md || grant_ls;
  assign any_held   = md_held || ls_held;
  assign pipe_stall = (starve_cnt == STARVE_MAX);

  // Retirement of a slow write is seen one cycle after its grant, on the
  // registered port; a same-edge re-issue to that register must stay pending.
  always_comb begin
    pend_next = pend_mask;
    if (rf_wen && (rf_src != SRC_PIPE)) pend_next = pend_next & ~reg_onehot(rf_waddr);
    if (iss_valid)                      pend_next = pend_next | reg_onehot(iss_waddr);
    pend_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wen     <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      rf_src     <= SRC_PIPE;
      last_grant <= RR_LS;
      starve_cnt <= 2'd0;
      pend_mask  <= '0;
    end else begin
      rf_wen <= grant_pipe || slow_grant;
      if (grant_pipe) begin
        rf_waddr <= pipe_waddr;
        rf_wdata <= pipe_wdata;
        rf_src   <= SRC_PIPE;
      end else if (grant_md) begin
        rf_waddr <= md_held_waddr;
        rf_wdata <= md_held_wdata;
        rf_src   <= SRC_MD;
      end else if (grant_ls) begin
        rf_waddr <= ls_held_waddr;
        rf_wdata <= ls_held_wdata;
        rf_src   <= SRC_LS;
      end

      if (grant_md)      last_grant <= RR_MD;
      else if (grant_ls) last_grant <= RR_LS;

      // Counts cycles a held slow result loses to the pipeline.
      if (slow_grant || !any_held)
        starve_cnt <= 2'd0;
      else if (grant_pipe && (starve_cnt != STARVE_MAX))
        starve_cnt <= starve_cnt + 2'd1;

      pend_mask <= pend_next;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: table of per-cycle vectors plus hand-written reset sequences.
// Combinational outputs are compared in the cycle they are driven; registered results go through a queue.
// Ports: none (top-level bench).
module tb_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        pipe_wen;
  logic [4:0]  pipe_waddr;
  logic [63:0] pipe_wdata;
  logic        md_valid, md_ready;
  logic [4:0]  md_waddr;
  logic [63:0] md_wdata;
  logic        ls_valid, ls_ready;
  logic [4:0]  ls_waddr;
  logic [63:0] ls_wdata;
  logic        iss_valid;
  logic [4:0]  iss_waddr;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic [31:0] pend_mask;
  logic        pipe_stall;

  wb_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .pipe_wen   (pipe_wen),
    .pipe_waddr (pipe_waddr),
    .pipe_wdata (pipe_wdata),
    .md_valid   (md_valid),
    .md_ready   (md_ready),
    .md_waddr   (md_waddr),
    .md_wdata   (md_wdata),
    .ls_valid   (ls_valid),
    .ls_ready   (ls_ready),
    .ls_waddr   (ls_waddr),
    .ls_wdata   (ls_wdata),
    .iss_valid  (iss_valid),
    .iss_waddr  (iss_waddr),
    .rf_wen     (rf_wen),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .pend_mask  (pend_mask),
    .pipe_stall (pipe_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        pw;  logic [4:0] pa;  logic [63:0] pd;
    logic        mv;  logic [4:0] ma;  logic [63:0] md;
    logic        lv;  logic [4:0] la;  logic [63:0] ld;
    logic        iv;  logic [4:0] ia;
    logic        emr; logic elr; logic est;
    logic        ew;  logic [4:0] ea;  logic [63:0] ed; logic [31:0] ep;
  } vec_t;

  typedef struct {
    int          id;
    logic        w;
    logic [4:0]  a;
    logic [63:0] d;
    logic [31:0] p;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;

  function automatic vec_t v(
    input logic r,
    input logic pw, input logic [4:0] pa, input logic [63:0] pd,
    input logic mv, input logic [4:0] ma, input logic [63:0] md,
    input logic lv, input logic [4:0] la, input logic [63:0] ld,
    input logic iv, input logic [4:0] ia,
    input logic emr, input logic elr, input logic est,
    input logic ew, input logic [4:0] ea, input logic [63:0] ed, input logic [31:0] ep);
    vec_t t;
    t.rst = r;
    t.pw = pw; t.pa = pa; t.pd = pd;
    t.mv = mv; t.ma = ma; t.md = md;
    t.lv = lv; t.la = la; t.ld = ld;
    t.iv = iv; t.ia = ia;
    t.emr = emr; t.elr = elr; t.est = est;
    t.ew = ew; t.ea = ea; t.ed = ed; t.ep = ep;
    return t;
  endfunction

  task automatic chk(input string nm, input int id, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @step %0d: got %h expected %h", nm, id, act, exp);
    end
  endtask

  task automatic check_regs();
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("rf_wen",    e.id, {63'd0, rf_wen},   {63'd0, e.w});
      chk("rf_waddr",  e.id, {59'd0, rf_waddr}, {59'd0, e.a});
      chk("rf_wdata",  e.id, rf_wdata,          e.d);
      chk("pend_mask", e.id, {32'd0, pend_mask}, {32'd0, e.p});
    end
  endtask

  task automatic step(input vec_t t);
    exp_t e;
    @(negedge clk);
    check_regs();
    rst        = t.rst;
    pipe_wen   = t.pw; pipe_waddr = t.pa; pipe_wdata = t.pd;
    md_valid   = t.mv; md_waddr   = t.ma; md_wdata   = t.md;
    ls_valid   = t.lv; ls_waddr   = t.la; ls_wdata   = t.ld;
    iss_valid  = t.iv; iss_waddr  = t.ia;
    #1;
    chk("md_ready",   step_id, {63'd0, md_ready},   {63'd0, t.emr});
    chk("ls_ready",   step_id, {63'd0, ls_ready},   {63'd0, t.elr});
    chk("pipe_stall", step_id, {63'd0, pipe_stall}, {63'd0, t.est});
    e.id = step_id; e.w = t.ew; e.a = t.ea; e.d = t.ed; e.p = t.ep;
    sb.push_back(e);
    step_id++;
  endtask

  localparam logic [63:0] BIG = 64'hDEAD_BEEF_0123_4567;

  initial begin
    vec_t tbl[$];

    rst = 1'b1;
    pipe_wen = 1'b0; pipe_waddr = '0; pipe_wdata = '0;
    md_valid = 1'b0; md_waddr = '0; md_wdata = '0;
    ls_valid = 1'b0; ls_waddr = '0; ls_wdata = '0;
    iss_valid = 1'b0; iss_waddr = '0;

    //             rst pw pa  pd       mv ma  md      lv la  ld      iv ia  emr elr est  ew ea  ed      ep
    // Reset: ready low even with valid sources; all registered outputs zero.
    tbl.push_back(v(1, 0, 0, 0,       1, 3, 1,       1, 4, 2,       1, 7,  0, 0, 0,   0, 0, 0,       32'h0));
    tbl.push_back(v(1, 1, 2, 5,       0, 0, 0,       0, 0, 0,       0, 0,  0, 0, 0,   0, 0, 0,       32'h0));
    // md write to r5 with r5 pending; retirement clears the bit one edge after rf_wen.
    tbl.push_back(v(0, 0, 0, 0,       0, 0, 0,       0, 0, 0,       1, 5,  1, 1, 0,   0, 0, 0,       32'h20));
    tbl.push_back(v(0, 0, 0, 0,       1, 5, 'hAA,    0, 0, 0,       0, 0,  1, 1, 0,   0, 0, 0,       32'h20));
    tbl.push_back(v(0, 0, 0, 0,       0, 0, 0,       0, 0, 0,       0, 0,  1, 1, 0,   1, 5, 'hAA,    32'h20));
    tbl.push_back(v(0, 0, 0, 0,       0, 0, 0,       0, 0, 0,       0, 0,  1, 1, 0,   0, 5, 'hAA,    32'h0));
    // Both holds loaded; last grant was md, so ls wins the tie, then md.
    tbl.push_back(v(0, 0, 0, 0,       1, 3, 'h33,    1, 4, 'h44,    1, 3,  1, 1, 0,   0, 5, 'hAA,    32'h08));
    tbl.push_back(v(0, 0, 0, 0,       0, 0, 0,       0, 0, 0,       0, 0,  0, 1, 0,   1, 4, 'h44,    32'h08));
    tbl.push_back(v(0, 0, 0, 0,       0, 0, 0,       0, 0, 0,       0, 0,  1, 1, 0,   1, 3, 'h33,    32'h08));
    tbl.push_back(v(0, 0, 0, 0,       0, 0, 0,       0, 0, 0,       0, 0,  1, 1, 0,   0, 3, 'h33,    32'h0));
    // Starvation: ls held while pipeline writes r7 each cycle; one contract violation at stall, then drop.
    tbl.push_back(v(0, 1, 7, 'h77,    0, 0, 0,       1, 6, 'h66,    0, 0,  1, 1, 0,   1, 7, 'h77,    32'h0));
    tbl.push_back(v(0, 1, 7, 'h78,    0, 0, 0,       0, 0, 0,       0, 0,  1, 0, 0,   1, 7, 'h78,    32'h0));
    tbl.push_back(v(0, 1, 7, 'h79,    0, 0, 0,       0, 0, 0,       0, 0,  1, 0, 0,   1, 7, 'h79,    32'h0));
    tbl.push_back(v(0, 1, 7, 'h7A,    0, 0, 0,       0, 0, 0,       0, 0,  1, 0, 0,   1, 7, 'h7A,    32'h0));
    tbl.push_back(v(0, 1, 7, 'h7B,    0, 0, 0,       0, 0, 0,       0, 0,  1, 0, 1,   1, 7, 'h7B,    32'h0));
    tbl.push_back(v(0, 0, 0, 0,       0, 0, 0,       0, 0, 0,       0, 0,  1, 1, 1,   1, 6, 'h66,    32'h0));
    tbl.push_back(v(0, 0, 0, 0,       0, 0, 0,       0, 0, 0,       0, 0,  1, 1, 0,   0, 6, 'h66,    32'h0));
    // Re-issue to r9 on the retirement edge keeps it pending; pipeline write to r9 does not clear it.
    tbl.push_back(v(0, 0, 0, 0,       1, 9, 'h99,    0, 0, 0,       1, 9,  1, 1, 0,   0, 6, 'h66,    32'h200));
    tbl.push_back(v(0, 0, 0, 0,       0, 0, 0,       0, 0, 0,       0, 0,  1, 1, 0,   1, 9, 'h99,    32'h200));
    tbl.push_back(v(0, 0, 0, 0,       0, 0, 0,       0, 0, 0,       1, 9,  1, 1, 0,   0, 9, 'h99,    32'h200));
    tbl.push_back(v(0, 1, 9, 'h1234,  0, 0, 0,       0, 0, 0,       0, 0,  1, 1, 0,   1, 9, 'h1234,  32'h200));
    tbl.push_back(v(0, 0, 0, 0,       0, 0, 0,       0, 0, 0,       0, 0,  1, 1, 0,   0, 9, 'h1234,  32'h200));
    // r0 targets: md result discarded, pipeline write ignored, issue to r0 ignored.
    tbl.push_back(v(0, 1, 0, 'h55,    1, 0, 'hFF,    0, 0, 0,       0, 0,  1, 1, 0,   0, 9, 'h1234,  32'h200));
    tbl.push_back(v(0, 0, 0, 0,       0, 0, 0,       0, 0, 0,       1, 0,  1, 1, 0,   0, 9, 'h1234,  32'h200));
    // Back-to-back md results, one per cycle.
    tbl.push_back(v(0, 0, 0, 0,       1, 10, 'hA0,   0, 0, 0,       0, 0,  1, 1, 0,   0, 9, 'h1234,  32'h200));
    tbl.push_back(v(0, 0, 0, 0,       1, 11, 'hA1,   0, 0, 0,       0, 0,  1, 1, 0,   1, 10, 'hA0,   32'h200));
    tbl.push_back(v(0, 0, 0, 0,       1, 12, BIG,    0, 0, 0,       0, 0,  1, 1, 0,   1, 11, 'hA1,   32'h200));
    tbl.push_back(v(0, 0, 0, 0,       0, 0, 0,       0, 0, 0,       0, 0,  1, 1, 0,   1, 12, BIG,    32'h200));
    tbl.push_back(v(0, 0, 0, 0,       0, 0, 0,       0, 0, 0,       0, 0,  1, 1, 0,   0, 12, BIG,    32'h200));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // Hand sequence: reset while both holds are full and pend_mask = 0x30 (plus r9).
    step(v(0, 0, 0, 0,       1, 3, 'h33,    1, 4, 'h44,    1, 4,  1, 1, 0,   0, 12, BIG,    32'h210));
    step(v(0, 1, 1, 'h11,    0, 0, 0,       0, 0, 0,       1, 5,  0, 0, 0,   1, 1, 'h11,    32'h230));
    step(v(1, 0, 0, 0,       1, 3, 'h33,    1, 4, 'h44,    0, 0,  0, 0, 0,   0, 0, 0,       32'h0));
    step(v(0, 0, 0, 0,       0, 0, 0,       0, 0, 0,       0, 0,  1, 1, 0,   0, 0, 0,       32'h0));
    // Hand sequence: post-reset tie goes to md first, then ls.
    step(v(0, 0, 0, 0,       1, 3, 'h33,    1, 4, 'h44,    0, 0,  1, 1, 0,   0, 0, 0,       32'h0));
    step(v(0, 0, 0, 0,       0, 0, 0,       0, 0, 0,       0, 0,  1, 0, 0,   1, 3, 'h33,    32'h0));
    step(v(0, 0, 0, 0,       0, 0, 0,       0, 0, 0,       0, 0,  1, 1, 0,   1, 4, 'h44,    32'h0));
    step(v(0, 0, 0, 0,       0, 0, 0,       0, 0, 0,       0, 0,  1, 1, 0,   0, 4, 'h44,    32'h0));

    @(negedge clk);
    check_regs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
